// File: rtl/clk_pkg.sv
// Shared types and constants for the clock divider controller.
package clk_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WAIT_LOW = 3'd2,
        HOLD     = 3'd3,
        SETTLE   = 3'd4
    } state_e;

    localparam int unsigned MIN_PRESCALER_DEF     = 2;
    localparam int unsigned DEFAULT_PRESCALER_DEF = 4;

    // Odd ratios cannot give equal phases, so they apply as N-1.
    function automatic logic [31:0] even_ratio(input logic [31:0] n);
        return n & ~32'd1;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Prescaler configuration handshake between a host and the controller.
interface clk_div_ctrl_if;
    logic        cfg_valid;
    logic [31:0] cfg_prescaler;
    logic        cfg_ready;
    logic        cfg_err;

    modport master (output cfg_valid, cfg_prescaler, input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_prescaler, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl_div.sv
// Divider datapath: 50% duty divide-by-prescaler_i, output straight from a flop.
module clk_div (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rise_en_i,
    input  logic [31:0] prescaler_i,
    output logic        clk_o
);
    logic [31:0] cnt_q;
    logic        out_q;
    logic [31:0] half_m1;

    assign half_m1 = (prescaler_i >> 1) - 32'd1;

    // A pending rise is held off while rise_en_i is low; falls are never blocked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (cnt_q == '0) begin
            if (out_q || rise_en_i) begin
                out_q <= ~out_q;
                cnt_q <= half_m1;
            end
        end else begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    assign clk_o = out_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer for a glitch-free reprogrammable clock divider.
//   state    | meaning
//   IDLE     | divider in reset, clk_out low, configs apply directly
//   RUN      | divider running
//   WAIT_LOW | finishing the current high phase before stopping
//   HOLD     | one cycle in reset, pending ratio applied
//   SETTLE   | SETTLE_CYCLES cycles in reset before restarting
module clk_div_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned MIN_PRESCALER     = MIN_PRESCALER_DEF,
    parameter int unsigned DEFAULT_PRESCALER = DEFAULT_PRESCALER_DEF,
    parameter int unsigned SETTLE_CYCLES     = 2
) (
    input  logic          clk_in,
    input  logic          arst_n,
    input  logic          enable,
    clk_div_ctrl_if.slave cfg,
    output logic          busy,
    output logic [31:0]   active_prescaler,
    output logic          clk_out
);
    localparam int unsigned   SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [31:0]   active_q, active_d, pend_q, pend_d;
    logic          reload_q, reload_d, err_q, err_d, run_q, run_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          cfg_ready, accept, cfg_bad, cfg_good;
    logic          rise_en, div_rst_n, div_out;

    assign accept   = cfg.cfg_valid && cfg_ready;
    assign cfg_bad  = accept && (cfg.cfg_prescaler < 32'(MIN_PRESCALER));
    assign cfg_good = accept && !cfg_bad;

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable) state_d = SETTLE;
            RUN:      if (cfg_good || !enable) state_d = WAIT_LOW;
            WAIT_LOW: if (!div_out) state_d = (reload_q && enable) ? HOLD : IDLE;
            HOLD:     state_d = enable ? SETTLE : IDLE;
            SETTLE: begin
                if (!enable)               state_d = IDLE;
                else if (settle_q == '0)   state_d = RUN;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == IDLE) || (state_q == RUN);
        busy      = (state_q == WAIT_LOW) || (state_q == HOLD) || (state_q == SETTLE);
        rise_en   = (state_q != WAIT_LOW);
    end

    // run_q is a flop so the divider reset never sees decode glitches.
    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        settle_d = settle_q;
        err_d    = cfg_bad;
        run_d    = (state_d == RUN) || (state_d == WAIT_LOW);
        case (state_q)
            IDLE: begin
                if (reload_q) begin
                    active_d = pend_q;
                    reload_d = 1'b0;
                end
                if (cfg_good) active_d = even_ratio(cfg.cfg_prescaler);
            end
            RUN: begin
                if (cfg_good) begin
                    pend_d   = even_ratio(cfg.cfg_prescaler);
                    reload_d = 1'b1;
                end
            end
            HOLD: begin
                active_d = pend_q;
                reload_d = 1'b0;
            end
            SETTLE: if (settle_q != '0) settle_d = settle_q - SW'(1);
            default: begin end
        endcase
        if (state_d == SETTLE && state_q != SETTLE) settle_d = SETTLE_LOAD;
    end

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            active_q <= 32'(DEFAULT_PRESCALER);
            pend_q   <= '0;
            reload_q <= 1'b0;
            err_q    <= 1'b0;
            run_q    <= 1'b0;
            settle_q <= '0;
        end else begin
            active_q <= active_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            err_q    <= err_d;
            run_q    <= run_d;
            settle_q <= settle_d;
        end
    end

    assign div_rst_n        = arst_n & run_q;
    assign cfg.cfg_ready    = cfg_ready;
    assign cfg.cfg_err      = err_q;
    assign active_prescaler = active_q;

    clk_div u_div (
        .clk_i       (clk_in),
        .rst_ni      (div_rst_n),
        .rise_en_i   (rise_en),
        .prescaler_i (active_q),
        .clk_o       (div_out)
    );

    assign clk_out = div_out;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scenario bench for clk_div_ctrl; expectations come from waveform-level rules.
module tb_clk_div_ctrl;
    localparam int SETTLE = 2;
    localparam int MIN_P  = 2;
    localparam int DEF_P  = 4;

    logic        clk_in = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic        busy, clk_out;
    logic [31:0] active_prescaler;

    clk_div_ctrl_if cfg_if();

    clk_div_ctrl #(
        .MIN_PRESCALER     (MIN_P),
        .DEFAULT_PRESCALER (DEF_P),
        .SETTLE_CYCLES     (SETTLE)
    ) dut (
        .clk_in           (clk_in),
        .arst_n           (arst_n),
        .enable           (enable),
        .cfg              (cfg_if),
        .busy             (busy),
        .active_prescaler (active_prescaler),
        .clk_out          (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    int model_active = DEF_P;
    bit tr[$];
    bit bt[$];
    bit et[$];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Index 0 is the value before the first edge; cfg_valid is dropped after one edge.
    task automatic record(input int n);
        tr.delete(); bt.delete(); et.delete();
        tr.push_back(clk_out); bt.push_back(busy); et.push_back(cfg_if.cfg_err);
        for (int i = 0; i < n; i++) begin
            step();
            cfg_if.cfg_valid = 1'b0;
            tr.push_back(clk_out); bt.push_back(busy); et.push_back(cfg_if.cfg_err);
        end
    endtask

    function automatic int find_val(input int start, input bit v);
        if (start < 0) return -1;
        for (int i = start; i < tr.size(); i++) if (tr[i] == v) return i;
        return -1;
    endfunction

    function automatic int count_ones(input bit q[$], input int start);
        int c = 0;
        for (int i = start; i < q.size(); i++) if (q[i]) c++;
        return c;
    endfunction

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bit p;
            p = clk_out;
            step();
            if (!p && clk_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_prescaler = '0;
        enable = 1'b0;
        arst_n = 1'b0;
        step(); step();
        n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b want 0", cfg_if.cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", cfg_if.cfg_ready); end
        n_cmp++; if (active_prescaler !== 32'(DEF_P)) begin n_err++; $display("FAIL reset_active got %0d want %0d", active_prescaler, DEF_P); end
        arst_n = 1'b1;
        model_active = DEF_P;
        step(); step();
        n_cmp++; if (clk_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset clk_out=%b busy=%b want 0/0", clk_out, busy); end
    endtask

    // From IDLE: first rise SETTLE+1 edges after the enable sample, then even phases.
    task automatic test_startup();
        int r, f, r2;
        enable = 1'b1;
        record(SETTLE + model_active + 6);
        r  = find_val(0, 1'b1);
        f  = find_val(r, 1'b0);
        r2 = find_val(f, 1'b1);
        n_cmp++; if (r != SETTLE + 2) begin n_err++; $display("FAIL startup_first_rise got idx %0d want %0d", r, SETTLE + 2); end
        n_cmp++; if (f - r != model_active / 2) begin n_err++; $display("FAIL startup_high got %0d want %0d", f - r, model_active / 2); end
        n_cmp++; if (r2 - f != model_active / 2) begin n_err++; $display("FAIL startup_low got %0d want %0d", r2 - f, model_active / 2); end
        n_cmp++; if (count_ones(bt, 0) != SETTLE) begin n_err++; $display("FAIL startup_busy_len got %0d want %0d", count_ones(bt, 0), SETTLE); end
        n_cmp++; if (active_prescaler !== 32'(model_active)) begin n_err++; $display("FAIL startup_active got %0d want %0d", active_prescaler, model_active); end
    endtask

    task automatic test_reload(input int v);
        int oldr, newr, f, r2, f2, r3;
        bit ok;
        oldr = model_active;
        newr = v & ~1;
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reload_wait_rise got timeout want rise"); end
        cfg_if.cfg_prescaler = 32'(v);
        cfg_if.cfg_valid = 1'b1;
        record(oldr / 2 + newr + SETTLE + 8);
        model_active = newr;
        f  = find_val(0, 1'b0);
        r2 = find_val(f, 1'b1);
        f2 = find_val(r2, 1'b0);
        r3 = find_val(f2, 1'b1);
        n_cmp++; if (f != oldr / 2) begin n_err++; $display("FAIL reload_old_high v=%0d got %0d want %0d", v, f, oldr / 2); end
        n_cmp++; if (r2 - f != SETTLE + 3) begin n_err++; $display("FAIL reload_gap v=%0d got %0d want %0d", v, r2 - f, SETTLE + 3); end
        n_cmp++; if (f2 - r2 != newr / 2) begin n_err++; $display("FAIL reload_new_high v=%0d got %0d want %0d", v, f2 - r2, newr / 2); end
        n_cmp++; if (r3 - f2 != newr / 2) begin n_err++; $display("FAIL reload_new_low v=%0d got %0d want %0d", v, r3 - f2, newr / 2); end
        n_cmp++; if (bt[1] !== 1'b1) begin n_err++; $display("FAIL reload_busy got %b want 1", bt[1]); end
        n_cmp++; if (active_prescaler !== 32'(newr)) begin n_err++; $display("FAIL reload_active v=%0d got %0d want %0d", v, active_prescaler, newr); end
    endtask

    task automatic test_invalid();
        int v, f, r2;
        bit ok;
        v = int'($urandom_range(0, MIN_P - 1));
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL invalid_wait_rise got timeout want rise"); end
        cfg_if.cfg_prescaler = 32'(v);
        cfg_if.cfg_valid = 1'b1;
        record(model_active + 6);
        f  = find_val(0, 1'b0);
        r2 = find_val(f, 1'b1);
        n_cmp++; if (et[1] !== 1'b1 || et[2] !== 1'b0) begin n_err++; $display("FAIL invalid_err_pulse got %b%b want 10", et[1], et[2]); end
        n_cmp++; if (count_ones(bt, 0) != 0) begin n_err++; $display("FAIL invalid_busy got %0d busy cycles want 0", count_ones(bt, 0)); end
        n_cmp++; if (f != model_active / 2 || r2 - f != model_active / 2) begin n_err++; $display("FAIL invalid_period got hi %0d lo %0d want %0d", f, r2 - f, model_active / 2); end
        n_cmp++; if (active_prescaler !== 32'(model_active)) begin n_err++; $display("FAIL invalid_active got %0d want %0d", active_prescaler, model_active); end
    endtask

    task automatic test_stop();
        int f;
        bit ok;
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stop_wait_rise got timeout want rise"); end
        enable = 1'b0;
        record(model_active + SETTLE + 6);
        f = find_val(0, 1'b0);
        n_cmp++; if (f != model_active / 2) begin n_err++; $display("FAIL stop_high got %0d want %0d", f, model_active / 2); end
        n_cmp++; if (count_ones(tr, f < 0 ? 0 : f) != 0) begin n_err++; $display("FAIL stop_quiet got %0d high cycles want 0", count_ones(tr, f < 0 ? 0 : f)); end
        n_cmp++; if (bt[1] !== 1'b1 || bt[bt.size() - 1] !== 1'b0) begin n_err++; $display("FAIL stop_busy got %b..%b want 1..0", bt[1], bt[bt.size() - 1]); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL stop_ready got %b want 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_settle_abort();
        enable = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_settle_busy got %b want 1", busy); end
        enable = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle busy=%b ready=%b want 0/1", busy, cfg_if.cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL abort_clk_out got %b want 0", clk_out); end
            step();
        end
    endtask

    task automatic test_idle_config();
        int v, bad;
        v = int'($urandom_range(MIN_P, 30));
        cfg_if.cfg_prescaler = 32'(v);
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        model_active = v & ~1;
        n_cmp++; if (active_prescaler !== 32'(model_active) || cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL idle_cfg v=%0d got %0d err %b want %0d err 0", v, active_prescaler, cfg_if.cfg_err, model_active); end
        bad = int'($urandom_range(0, MIN_P - 1));
        cfg_if.cfg_prescaler = 32'(bad);
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        n_cmp++; if (cfg_if.cfg_err !== 1'b1 || active_prescaler !== 32'(model_active)) begin n_err++; $display("FAIL idle_bad got err %b active %0d want 1 %0d", cfg_if.cfg_err, active_prescaler, model_active); end
        step();
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL idle_bad_len got %b want 0", cfg_if.cfg_err); end
        test_startup();
    endtask

    // HOLD lies old/2+1 edges after a write issued on the rising cycle.
    task automatic test_reset_in_hold();
        int v, oldr;
        bit ok;
        oldr = model_active;
        v = int'($urandom_range(6, 16));
        wait_rise(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_wait_rise got timeout want rise"); end
        cfg_if.cfg_prescaler = 32'(v);
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < oldr / 2; i++) step();
        n_cmp++; if (busy !== 1'b1 || active_prescaler !== 32'(oldr)) begin n_err++; $display("FAIL hold_reached busy=%b active=%0d want 1 %0d", busy, active_prescaler, oldr); end
        arst_n = 1'b0;
        #1;
        n_cmp++; if (clk_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_rst clk_out=%b busy=%b want 0/0", clk_out, busy); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL hold_rst ready=%b err=%b want 1/0", cfg_if.cfg_ready, cfg_if.cfg_err); end
        n_cmp++; if (active_prescaler !== 32'(DEF_P)) begin n_err++; $display("FAIL hold_rst_active got %0d want %0d", active_prescaler, DEF_P); end
        #1;
        arst_n = 1'b1;
        model_active = DEF_P;
        test_startup();
    endtask

    initial begin
        test_reset();
        test_startup();
        test_reload(8);
        test_reload(12);
        test_reload(7);
        for (int i = 0; i < 3; i++) test_reload(int'($urandom_range(MIN_P, 16)));
        test_invalid();
        test_stop();
        test_settle_abort();
        test_idle_config();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter MIN_PRESCALER, default 2, smallest prescaler accepted; values below it are rejected.
REQ-002 Parameter DEFAULT_PRESCALER, default 4, prescaler loaded at reset.
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles the divider is held in reset after a reload.
REQ-004 clk_in  in  1  sole clock; all flops rise-edge.
REQ-005 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  level; 1 requests a running output clock.
REQ-007 cfg_valid  in  1  new prescaler offered.
REQ-008 cfg_prescaler  in  32  offered divide ratio.
REQ-009 cfg_ready  out  1  controller can accept a config this cycle.
REQ-010 cfg_err  out  1  one-cycle pulse: accepted config was rejected.
REQ-011 busy  out  1  reconfiguration or stop in progress.
REQ-012 active_prescaler  out  32  ratio currently applied to the divider.
REQ-013 clk_out  out  1  divided clock, driven straight from the clk_div output flop.

Function
REQ-014 The block SHALL use states IDLE, RUN, WAIT_LOW, HOLD, SETTLE.
REQ-015 Transfer occurs on cfg_valid && cfg_ready; cfg_ready = (state is IDLE or RUN); no other cfg_valid effect.
REQ-016 Accepted value < MIN_PRESCALER: cfg_err high the next cycle for exactly one cycle; state and active_prescaler unchanged.
REQ-017 Accepted valid value: stored in a pending register with bit 0 cleared (odd N applies as N-1).
REQ-018 IDLE: divider held in reset, clk_out 0; a valid config updates active_prescaler the next cycle; enable=1 -> SETTLE.
REQ-019 RUN: divider released; valid config or enable=0 -> WAIT_LOW; both in the same cycle -> WAIT_LOW, config latched, then stop.
REQ-020 WAIT_LOW: leaves only in a cycle where the divider output is 0; -> HOLD if a reload is pending and enable=1, else -> IDLE.
REQ-021 HOLD: one cycle; divider reset asserted; active_prescaler <- pending value; -> SETTLE.
REQ-022 SETTLE: exactly SETTLE_CYCLES cycles, reset asserted; then -> RUN if enable=1, else IDLE.
REQ-023 enable=0 in HOLD or SETTLE -> IDLE next cycle; any reload performed in HOLD is kept.
REQ-024 Divider reset = arst_n AND a dedicated flop that is 1 only in RUN/WAIT_LOW; never a combinational state decode.
REQ-025 First clk_out rise = 1 cycle after RUN entry; high/low phases then each active_prescaler/2 cycles.
REQ-026 No high phase is truncated: clk_out falls only via the divider's own toggle or reset in a low phase.
REQ-027 busy = state in {WAIT_LOW, HOLD, SETTLE}.
REQ-028 active_prescaler drives the divider prescaler input and changes only in HOLD or IDLE.

Reset
REQ-029 arst_n low: state IDLE, clk_out 0, cfg_err 0, busy 0, cfg_ready 1, active_prescaler = DEFAULT_PRESCALER, pending cleared, divider in reset.
REQ-030 Reset mid-reconfiguration: pending value discarded; DEFAULT_PRESCALER is restored.

Structure
REQ-031 State encoding and MIN/DEFAULT constants SHALL live in shared package clk_pkg.
REQ-032 Exactly one sub-module SHALL be instantiated: clk_div (divider datapath); settle counter and FSM stay in clk_div_ctrl.

Verification
REQ-033 Reset release, enable=1, ratio 4 -> clk_out first rise 3 cycles after enable sample; period 4 cycles; busy pulses 2 cycles.
REQ-034 RUN at ratio 8, write 12 while clk_out high -> high phase completes 4 cycles; reload; then period 12; no pulse <4 cycles.
REQ-035 Write 1 in RUN -> cfg_err one cycle; period and active_prescaler unchanged; busy stays 0.
REQ-036 Write 7 -> active_prescaler 6; period 6 cycles.
REQ-037 enable=0 during SETTLE -> IDLE next cycle; clk_out stays 0; cfg_ready 1.
REQ-038 arst_n pulsed low in HOLD -> all outputs at reset values immediately; active_prescaler 4.
